// File: rtl/enigma_byte_packer.sv
// Packs 6-bit enigma cipher symbols four at a time into 24-bit words.
// Words pass through a small FIFO and leave as bytes on a valid/ready port.
module enigma_byte_packer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          code_valid,
    input  logic [5:0]    code_in,
    input  logic          flush,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_last,
    output logic [AW:0]   fifo_count,
    output logic          overflow
);

    typedef struct packed {
        logic [23:0] word;
        logic [1:0]  nbytes;
        logic        last;
    } entry_t;

    typedef enum logic [1:0] {IDLE, B0, B1, B2} state_t;

    // ---------------- packing ----------------
    logic [1:0]  gcnt;
    logic [23:0] acc;
    logic [23:0] acc_next;
    logic [2:0]  pend;
    logic        full_push;
    logic        push;
    entry_t      push_entry;

    always_comb begin
        acc_next = acc;
        if (code_valid) begin
            case (gcnt)
                2'd0:    acc_next[23:18] = code_in;
                2'd1:    acc_next[17:12] = code_in;
                2'd2:    acc_next[11:6]  = code_in;
                default: acc_next[5:0]   = code_in;
            endcase
        end
    end

    // pend counts the symbol captured on this same edge
    assign pend      = {1'b0, gcnt} + {2'b00, code_valid};
    assign full_push = code_valid && (gcnt == 2'd3);
    assign push      = full_push || (flush && (pend != 3'd0));

    assign push_entry.word   = acc_next;
    assign push_entry.nbytes = full_push ? 2'd3 : pend[1:0];
    assign push_entry.last   = !full_push;

    always_ff @(posedge clk) begin
        if (srst) begin
            gcnt <= 2'd0;
            acc  <= 24'd0;
        end else if (push) begin
            gcnt <= 2'd0;
            acc  <= 24'd0;
        end else if (code_valid) begin
            gcnt <= gcnt + 2'd1;
            acc  <= acc_next;
        end
    end

    // ---------------- word FIFO ----------------
    entry_t      mem [DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic        wr_en;
    entry_t      head;

    assign fifo_count = wptr - rptr;
    assign fifo_full  = (fifo_count == (AW+1)'(DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign wr_en      = push && (!fifo_full || pop);
    assign head       = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wptr[AW-1:0]] <= push_entry;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en)
                wptr <= wptr + (AW+1)'(1);
            if (pop)
                rptr <= rptr + (AW+1)'(1);
            if (push && !wr_en)
                overflow <= 1'b1;
        end
    end

    // ---------------- serializer ----------------
    state_t state;
    entry_t hold;
    logic   final_byte;
    logic   fire;

    always_comb begin
        case (state)
            B0:      final_byte = (hold.nbytes == 2'd1);
            B1:      final_byte = (hold.nbytes == 2'd2);
            B2:      final_byte = 1'b1;
            default: final_byte = 1'b0;
        endcase
    end

    assign fire = out_valid && out_ready;
    // reload on the final-byte handshake so words run back to back
    assign pop  = !fifo_empty && ((state == IDLE) || (fire && final_byte));

    always_ff @(posedge clk) begin
        if (srst) begin
            state     <= IDLE;
            hold      <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'd0;
            out_last  <= 1'b0;
        end else if (pop) begin
            state     <= B0;
            hold      <= head;
            out_valid <= 1'b1;
            out_data  <= head.word[23:16];
            out_last  <= head.last && (head.nbytes == 2'd1);
        end else if (fire) begin
            if (final_byte) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else if (state == B0) begin
                state    <= B1;
                out_data <= hold.word[15:8];
                out_last <= hold.last && (hold.nbytes == 2'd2);
            end else begin
                state    <= B2;
                out_data <= hold.word[7:0];
                out_last <= hold.last;
            end
        end
    end

endmodule
